// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed hex 7-segment scanner with frame-coherent
// snapshot, leading-zero blanking, anti-ghost guard time and PWM dimming.
// All display outputs are registered one clock behind the scan counters.
// There are no handshakes: value/dp_in/lzb_en are sampled only at the frame
// wrap, and enable/brightness act on the very next clock.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD         = 16,
  parameter bit AN_ACTIVE_LOW = 1'b1,
  localparam int IDX_W = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lzb_en,
  input  logic                    enable,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [3:0]              nibble,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_start
);

  localparam int PRE_W = $clog2(REFRESH_DIV);

  logic [PRE_W-1:0]        pre_cnt;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              pwm_cnt;
  logic [4*NUM_DIGITS-1:0] snap_value;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic                    snap_lzb;
  logic                    wrap_d;

  logic                    tick;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    zero_tail;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    lit;
  logic                    drive;
  logic [NUM_DIGITS-1:0]   act;

  // Active-low gfedcba hex font.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick = (pre_cnt == PRE_W'(REFRESH_DIV - 1));
  assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

  // Prescaler, slot index and free-running PWM counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      idx     <= '0;
      pwm_cnt <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (tick) pre_cnt <= '0;
      else      pre_cnt <= pre_cnt + PRE_W'(1);
      if (wrap)      idx <= '0;
      else if (tick) idx <= idx + IDX_W'(1);
    end
  end

  // Snapshot taken on the wrap edge so a whole frame shows one coherent value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_value <= '0;
      snap_dp    <= '0;
      snap_lzb   <= 1'b0;
    end else if (wrap) begin
      snap_value <= value;
      snap_dp    <= dp_in;
      snap_lzb   <= lzb_en;
    end
  end

  // Leading-zero mask: digit i>0 blanks when it and every digit above are zero.
  always_comb begin
    blank     = '0;
    zero_tail = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_tail = zero_tail && (snap_value[4*i +: 4] == 4'h0);
      if (i != 0) blank[i] = snap_lzb && zero_tail;
    end
  end

  // Select the current digit's nibble, dp and blank flag from the snapshot.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = snap_value[4*i +: 4];
        cur_dp    = snap_dp[i];
        cur_blank = blank[i];
      end
    end
  end

  // Anode gating: enable, past the guard window, PWM lit, and not blanked.
  always_comb begin
    lit   = (brightness == 4'hF) || (pwm_cnt < brightness);
    drive = enable && (pre_cnt >= PRE_W'(GUARD)) && lit && !cur_blank;
    act   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      act[i] = drive && (idx == IDX_W'(i));
    end
  end

  // Output registers; frame_start is delayed twice so it lines up with digit_idx==0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      seg         <= 7'h7F;
      dp          <= 1'b1;
      nibble      <= 4'h0;
      digit_idx   <= '0;
      wrap_d      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      an          <= AN_ACTIVE_LOW ? ~act : act;
      seg         <= drive ? hex7(cur_nib) : 7'h7F;
      dp          <= drive ? ~cur_dp : 1'b1;
      nibble      <= cur_nib;
      digit_idx   <= idx;
      wrap_d      <= wrap;
      frame_start <= wrap_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (N=4, REFRESH_DIV=20, GUARD=4, active-low anodes).
module tb_seg7_scan_ctrl;

  localparam int N    = 4;
  localparam int DIV  = 20;
  localparam int GRD  = 4;
  localparam int SLOT = DIV;
  localparam int FRAME = N * DIV;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lzb_en;
  logic        enable;
  logic [3:0]  brightness;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  nibble;
  logic [1:0]  digit_idx;
  logic        frame_start;

  int n_checks;
  int n_pass;

  // Per-frame observations gathered by observe_frame.
  int         lit_cnt[N];
  int         dp_lo_cnt[N];
  logic [3:0] mid_nib[N];
  logic [6:0] mid_seg[N];
  logic [1:0] mid_idx[N];
  int         bad_an;
  int         fs_cnt;
  int         rel_cnt;

  seg7_scan_ctrl #(
    .NUM_DIGITS(N),
    .REFRESH_DIV(DIV),
    .GUARD(GRD),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .value(value),
    .dp_in(dp_in),
    .lzb_en(lzb_en),
    .enable(enable),
    .brightness(brightness),
    .an(an),
    .seg(seg),
    .dp(dp),
    .nibble(nibble),
    .digit_idx(digit_idx),
    .frame_start(frame_start)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Step at least one negedge, then stop on the first negedge with frame_start high.
  task automatic wait_fs();
    for (int k = 0; k < 4 * FRAME; k++) begin
      @(negedge clk);
      if (frame_start) return;
    end
    check_eq("wait_fs_timeout", 32'd0, 32'd1);
  endtask

  // Watch one whole frame starting at the next frame_start; optionally change value mid-frame.
  task automatic observe_frame(input int chg_at, input logic [15:0] chg_val);
    logic [3:0] act_lo;
    logic [3:0] exp_mask;
    int         slot;
    wait_fs();
    bad_an = 0;
    fs_cnt = 0;
    for (int s = 0; s < N; s++) begin
      lit_cnt[s]   = 0;
      dp_lo_cnt[s] = 0;
    end
    for (int c = 0; c < FRAME; c++) begin
      slot     = c / SLOT;
      act_lo   = ~an;
      exp_mask = 4'(1 << slot);
      if ((act_lo & ~exp_mask) != 4'h0) bad_an++;
      if (act_lo == exp_mask) lit_cnt[slot]++;
      if (!dp) dp_lo_cnt[slot]++;
      if (frame_start) fs_cnt++;
      if ((c % SLOT) == 10) begin
        mid_nib[slot] = nibble;
        mid_seg[slot] = seg;
        mid_idx[slot] = digit_idx;
      end
      if (c == chg_at) value = chg_val;
      if (c < FRAME - 1) @(negedge clk);
    end
  endtask

  task automatic check_lit(input string tag, input int e0, input int e1, input int e2, input int e3);
    check_eq({tag, "_lit0"}, lit_cnt[0], e0);
    check_eq({tag, "_lit1"}, lit_cnt[1], e1);
    check_eq({tag, "_lit2"}, lit_cnt[2], e2);
    check_eq({tag, "_lit3"}, lit_cnt[3], e3);
    check_eq({tag, "_bad_an"}, bad_an, 0);
    check_eq({tag, "_fs_cnt"}, fs_cnt, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_an"}, an, 4'hF);
    check_eq({tag, "_seg"}, seg, 7'h7F);
    check_eq({tag, "_dp"}, dp, 1'b1);
    check_eq({tag, "_fs"}, frame_start, 1'b0);
    check_eq({tag, "_nibble"}, nibble, 4'h0);
    check_eq({tag, "_idx"}, digit_idx, 2'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    value      = 16'h1234;
    dp_in      = 4'b0010;
    lzb_en     = 1'b0;
    enable     = 1'b1;
    brightness = 4'd15;

    // Reset held for 5 clocks; outputs stay at reset values.
    @(negedge clk);
    check_reset_outputs("rst_c1");
    repeat (4) @(negedge clk);
    check_reset_outputs("rst_c5");

    // First frame after release shows the cleared snapshot (digit 0 = '0').
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("zero_nibble", nibble, 4'h0);
    check_eq("zero_an", an, 4'b1110);
    check_eq("zero_seg", seg, 7'h40);
    check_eq("zero_dp", dp, 1'b1);

    // Scan order, guard window and decode.
    observe_frame(-1, 16'h0);
    check_lit("scan", 16, 16, 16, 16);
    check_eq("scan_nib0", mid_nib[0], 4'h4);
    check_eq("scan_nib1", mid_nib[1], 4'h3);
    check_eq("scan_nib2", mid_nib[2], 4'h2);
    check_eq("scan_nib3", mid_nib[3], 4'h1);
    check_eq("scan_seg0", mid_seg[0], 7'h19);
    check_eq("scan_seg3", mid_seg[3], 7'h79);
    check_eq("scan_idx1", mid_idx[1], 2'd1);
    check_eq("scan_idx3", mid_idx[3], 2'd3);
    check_eq("scan_dp0", dp_lo_cnt[0], 0);
    check_eq("scan_dp1", dp_lo_cnt[1], 16);

    // Snapshot: value changes during digit-1 slot, visible only next frame.
    observe_frame(30, 16'hABCD);
    check_eq("snap_nib2", mid_nib[2], 4'h2);
    check_eq("snap_nib3", mid_nib[3], 4'h1);
    observe_frame(-1, 16'h0);
    check_eq("snap_next_nib0", mid_nib[0], 4'hD);
    check_eq("snap_next_nib1", mid_nib[1], 4'hC);
    check_eq("snap_next_nib2", mid_nib[2], 4'hB);
    check_eq("snap_next_nib3", mid_nib[3], 4'hA);
    check_eq("snap_next_seg0", mid_seg[0], 7'h21);

    // Leading-zero blanking; dp on a blanked digit is ignored.
    value  = 16'h0050;
    lzb_en = 1'b1;
    dp_in  = 4'b0100;
    wait_fs();
    observe_frame(-1, 16'h0);
    check_lit("lzb50", 16, 16, 0, 0);
    check_eq("lzb50_seg0", mid_seg[0], 7'h40);
    check_eq("lzb50_nib1", mid_nib[1], 4'h5);
    check_eq("lzb50_seg1", mid_seg[1], 7'h12);
    check_eq("lzb50_dp2", dp_lo_cnt[2], 0);

    value = 16'h0000;
    wait_fs();
    observe_frame(-1, 16'h0);
    check_lit("lzb00", 16, 0, 0, 0);
    check_eq("lzb00_seg0", mid_seg[0], 7'h40);

    // PWM brightness and enable gating.
    value      = 16'h1234;
    lzb_en     = 1'b0;
    dp_in      = 4'b0000;
    brightness = 4'd4;
    wait_fs();
    observe_frame(-1, 16'h0);
    check_lit("bri4", 4, 4, 4, 4);

    brightness = 4'd0;
    wait_fs();
    observe_frame(-1, 16'h0);
    check_lit("bri0", 0, 0, 0, 0);

    brightness = 4'd15;
    enable     = 1'b0;
    wait_fs();
    observe_frame(-1, 16'h0);
    check_lit("dis", 0, 0, 0, 0);

    // Reset asserted mid digit-2 slot.
    enable = 1'b1;
    wait_fs();
    repeat (45) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("midrst_idx", digit_idx, 2'd0);
    check_eq("midrst_nib", nibble, 4'h0);
    check_eq("midrst_an", an, 4'b1110);
    check_eq("midrst_seg", seg, 7'h40);
    rel_cnt = 10;
    while (!frame_start && rel_cnt < 4 * FRAME) begin
      @(negedge clk);
      rel_cnt++;
    end
    check_eq("midrst_first_fs", rel_cnt, FRAME + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
